// File: rtl/smg_scan_display_param.sv
// Multiplexed seven-segment driver: frame-latched hex value, leading-zero blanking, dp/mask, 16-level brightness.
// Latency: segment/select outputs are registered, one cycle behind the dwell counter and digit index.
// Backpressure: none; inputs are sampled once per frame and the scan free-runs.
module smg_scan_display_param #(
  parameter int DIGITS  = 6,
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_US = 1000
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [4*DIGITS-1:0]   number_sig,
  input  logic [DIGITS-1:0]     dp_sig,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  input  logic                  disp_en,
  output logic [7:0]            smg_data,
  output logic [DIGITS-1:0]     scan_sig,
  output logic                  frame_done
);

  localparam int DWELL    = CLK_HZ / 1_000_000 * SCAN_US;
  localparam int SLOT_LEN = DWELL / 16;
  localparam int CNT_W    = $clog2(DWELL);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("smg_scan_display_param: DIGITS must be 1..8");
  end
  if (DWELL < 32 || (DWELL % 16) != 0) begin : g_bad_dwell
    $error("smg_scan_display_param: DWELL must be >= 32 and a multiple of 16");
  end

  logic [CNT_W-1:0]    dwell_cnt;
  logic [IDX_W-1:0]    idx;
  logic                first_q;
  logic                dwell_end;
  logic                latch;

  logic [4*DIGITS-1:0] num_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic                lz_q;
  logic [3:0]          bright_q;
  logic                en_q;

  logic [DIGITS-1:0]   supp;
  logic                lead;
  logic [DIGITS-1:0]   sel_oh;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_supp;
  logic [CNT_W:0]      lim;
  logic                drive;
  logic [7:0]          glyph_raw;
  logic [7:0]          seg_nxt;
  logic [DIGITS-1:0]   scan_nxt;

  assign dwell_end = (dwell_cnt == CNT_W'(DWELL - 1));
  // Latch on the last cycle of the last digit, and once straight out of reset.
  assign latch     = first_q || (dwell_end && idx == IDX_W'(DIGITS - 1));

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  // Dwell counter and digit index; first_q marks the post-reset latch cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dwell_cnt <= '0;
      idx       <= '0;
      first_q   <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (dwell_end) begin
        dwell_cnt <= '0;
        idx       <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

  // Frame-synchronous capture of everything that affects the picture.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      num_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      lz_q     <= 1'b0;
      bright_q <= '0;
      en_q     <= 1'b0;
    end else if (latch) begin
      num_q    <= number_sig;
      dp_q     <= dp_sig;
      blank_q  <= blank_mask;
      lz_q     <= lz_en;
      bright_q <= bright;
      en_q     <= disp_en;
    end
  end

  // Leading-zero suppression: walk down from the top digit until a nonzero nibble or lit dp.
  always_comb begin
    supp = '0;
    lead = lz_q;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && num_q[4*k +: 4] == 4'h0 && !dp_q[k]) supp[k] = 1'b1;
      else lead = 1'b0;
    end
  end

  // Pick the attributes of the digit currently being scanned.
  always_comb begin
    sel_oh    = '0;
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_oh[k] = 1'b1;
        cur_nib   = num_q[4*k +: 4];
        cur_dp    = dp_q[k];
        cur_blank = blank_q[k];
        cur_supp  = supp[k];
      end
    end
  end

  // Drive window: skip the dead cycle at dwell start, stop once the brightness slot is exceeded.
  always_comb begin
    lim       = (CNT_W + 1)'((int'(bright_q) + 1) * SLOT_LEN);
    drive     = en_q && (dwell_cnt != '0) && ({1'b0, dwell_cnt} < lim) && !cur_blank;
    glyph_raw = glyph(cur_nib);
    seg_nxt   = 8'hFF;
    scan_nxt  = '1;
    if (drive) begin
      scan_nxt = ~sel_oh;
      seg_nxt  = cur_supp ? 8'hFF : {glyph_raw[7] & ~cur_dp, glyph_raw[6:0]};
    end
  end

  // Registered pin outputs; reset darkens the display immediately.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      smg_data   <= 8'hFF;
      scan_sig   <= '1;
      frame_done <= 1'b0;
    end else begin
      smg_data   <= seg_nxt;
      scan_sig   <= scan_nxt;
      frame_done <= latch;
    end
  end

endmodule

// File: doc/smg_scan_display_param.md
Name: smg_scan_display_param

Overview:
Parametrised multiplexed seven-segment driver. It takes a packed hex value of DIGITS nibbles and time-multiplexes it onto a common segment bus plus one digit-select line per digit. Over the fixed 6-digit interface it adds:
- frame-synchronous input latching, so the display never tears
- leading-zero suppression
- per-digit decimal point and blank mask
- 16-level brightness gating
- a frame_done strobe

It sits between application logic (counters, EEPROM readback, etc.) and the board's display pins.

Parameters:
DIGITS, 6, number of digits (legal 1..8)
CLK_HZ, 50_000_000, CLK frequency in Hz
SCAN_US, 1000, dwell time per digit in microseconds; DWELL = CLK_HZ/1_000_000*SCAN_US cycles, must be >=32 and a multiple of 16 (elaboration error otherwise)

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
number_sig  input  4*DIGITS  packed hex value; nibble k drives digit k (digit 0 = rightmost)
dp_sig  input  DIGITS  decimal point request per digit, 1 = lit
blank_mask  input  DIGITS  1 = force digit k dark (segments and dp)
lz_en  input  1  1 = suppress leading zeros
bright  input  4  brightness level 0..15
disp_en  input  1  0 = all digits dark; scanning continues
smg_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered
scan_sig  output  DIGITS  digit select, active-low, registered
frame_done  output  1  one-cycle pulse at each frame latch

Behaviour:
- Reset (asynchronous, RSTn=0):
  - smg_data=8'hFF, scan_sig=all ones, frame_done=0.
  - dwell_cnt=0, digit index idx=0, latched regs=0.
  - The first cycle after release is a latch cycle.
- dwell_cnt counts 0..DWELL-1 and then wraps. idx increments at each wrap, going from DIGITS-1 back to 0.
- Frame latch:
  - Occurs on the cycle where dwell_cnt=DWELL-1 and idx=DIGITS-1, and on the first cycle after reset.
  - Captures number_sig, dp_sig, blank_mask, lz_en, bright and disp_en.
  - frame_done=1 for exactly that cycle.
  - Input changes between latches are invisible until the next frame.
- Leading-zero suppression (computed from latched data):
  - Scanning from digit DIGITS-1 down to 1, a digit is suppressed while its nibble=0 and its dp bit=0.
  - Suppression stops at the first digit that is nonzero or has dp set.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Glyph table, active-low, dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. A set dp bit clears bit7.
- Suppressed or blank_mask digit: segment byte = 8'hFF; dp is also dark if masked. blank_mask overrides dp.
- Brightness: slot = dwell_cnt / (DWELL/16), range 0..15. The digit is driven only while slot <= bright_latched.
- Dead cycle: on dwell_cnt=0, scan_sig=all ones and smg_data=8'hFF (anti-ghosting).
- Driven cycle: scan_sig has only bit idx low; smg_data = glyph for idx.
- Otherwise, and whenever disp_en_latched=0: scan_sig all ones, smg_data=8'hFF.
- Output latency: outputs are registered and lag dwell_cnt/idx by 1 cycle. At most one scan_sig bit is low in any cycle.
- Reset mid-frame: outputs go dark immediately (asynchronous). Scanning restarts at idx 0 with a fresh latch.

Test Plan:
Sim parameters: DIGITS=6, CLK_HZ=1_000_000, SCAN_US=32, so DWELL=32 and slot length = 2 cycles.
1. Reset release, number_sig=24'h12AB0F, lz_en=0, bright=15, disp_en=1 -> frame_done pulses on cycle 1. Digits 0..5 show 8E,C0,83,88,A4,F9 in turn. Each digit is driven 31 of 32 cycles (dead cycle at dwell start). Frame period is 192 cycles.
2. number_sig=24'h000050, lz_en=1, dp_sig=0 -> digits 5..2 are 8'hFF, digit1=92, digit0=C0. Then dp_sig=6'b001000 -> digit3 shows 40 and digit2 shows C0 (suppression stops at the dp digit).
3. Change number_sig from 24'h111111 to 24'h222222 mid-frame (idx=2) -> digits 2..5 still show F9 until frame_done; the next frame shows A4 on all digits.
4. bright=0 -> each digit is driven only on dwell_cnt 1 (1 cycle of 32). bright=7 -> driven on dwell_cnt 1..15.
5. blank_mask=6'b000001 with dp_sig=6'b000001, then disp_en=0 -> digit0 stays dark, scan_sig bit0 never low. With disp_en=0 (after the next latch), scan_sig=6'b111111 and smg_data=8'hFF for the whole frame while frame_done keeps pulsing every 192 cycles.
6. Assert RSTn=0 asynchronously mid-dwell -> smg_data=8'hFF and scan_sig=6'b111111 in the same cycle without waiting for CLK. After release, scanning restarts at digit 0 and frame_done pulses on cycle 1.
